// File: rtl/mandelbrot_pixel_engine.sv
// Escape-time Mandelbrot renderer for a 160x120 frame: scans pixels in raster
// order, iterates z <- z^2 + c one step per cycle and emits one plot per pixel.
module mandelbrot_pixel_engine #(
  parameter int MAX_ITER = 16,
  parameter int WIDTH    = 18,
  parameter int FRAC     = 13,
  parameter int X_MIN    = -16384,
  parameter int Y_MIN    = -9216,
  parameter int STEP     = 154
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  localparam int PW = 2 * WIDTH;
  localparam logic signed [WIDTH-1:0] X_MIN_W = WIDTH'(X_MIN);
  localparam logic signed [WIDTH-1:0] Y_MIN_W = WIDTH'(Y_MIN);
  localparam logic signed [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  // |z|^2 > 4 in the product's 2*FRAC fixed-point scale
  localparam logic signed [PW:0]      ESC_LIM = (PW+1)'(1) << (2 * FRAC + 2);

  typedef enum logic [2:0] {IDLE, INIT, ITER, PLOT, DONE} state_t;

  state_t                   state;
  logic [7:0]               x;
  logic [6:0]               y;
  logic [7:0]               n;
  logic signed [WIDTH-1:0]  cr, ci, zr, zi;
  logic signed [WIDTH-1:0]  zr_next, zi_next;
  logic signed [PW-1:0]     zr_sq, zi_sq, zr_zi;
  logic signed [PW:0]       mag;
  logic                     escaped, at_cap;

  function automatic logic signed [WIDTH-1:0] shift_trunc(
    input logic signed [PW-1:0] v,
    input int                   sh
  );
    logic signed [PW-1:0] s;
    s = v >>> sh;
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [2:0] colour_of(input logic [7:0] cnt);
    if (cnt == 8'(MAX_ITER)) return 3'd0;
    if (cnt[2:0] == 3'd0)    return 3'b111;
    return cnt[2:0];
  endfunction

  always_comb begin
    zr_sq   = PW'(zr) * PW'(zr);
    zi_sq   = PW'(zi) * PW'(zi);
    zr_zi   = PW'(zr) * PW'(zi);
    mag     = (PW+1)'(zr_sq) + (PW+1)'(zi_sq);
    escaped = (mag > ESC_LIM);
    at_cap  = (n == 8'(MAX_ITER));
    zr_next = shift_trunc(zr_sq - zi_sq, FRAC) + cr;
    // 2*zr*zi folded into a shift one bit shorter
    zi_next = shift_trunc(zr_zi, FRAC - 1) + ci;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      done       <= 1'b0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      vga_plot <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= INIT;
            done  <= 1'b0;
            x     <= '0;
            y     <= '0;
            cr    <= X_MIN_W;
            ci    <= Y_MIN_W;
          end
        end
        INIT: begin
          zr    <= '0;
          zi    <= '0;
          n     <= '0;
          state <= ITER;
        end
        ITER: begin
          if (escaped || at_cap) begin
            state      <= PLOT;
            vga_plot   <= 1'b1;
            vga_x      <= x;
            vga_y      <= y;
            vga_colour <= colour_of(n);
          end else begin
            zr <= zr_next;
            zi <= zi_next;
            n  <= n + 8'd1;
          end
        end
        PLOT: begin
          if (x < 8'd159) begin
            x     <= x + 8'd1;
            cr    <= cr + STEP_W;
            state <= INIT;
          end else if (y < 7'd119) begin
            x     <= '0;
            cr    <= X_MIN_W;
            y     <= y + 7'd1;
            ci    <= ci + STEP_W;
            state <= INIT;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mandelbrot_pixel_engine.sv
// Bench for mandelbrot_pixel_engine: three instances (default, a c-offset one
// whose first pixel is in-set, and MAX_ITER=1 for a fast full frame).
module tb_mandelbrot_pixel_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pcyc = 0;
  always @(posedge clk) pcyc <= pcyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint wrap18(input longint v);
    longint m;
    m = v & 64'h3FFFF;
    if (m >= 131072) m = m - 262144;
    return m;
  endfunction

  function automatic int ref_count(input int px, input int py, input int xmin,
                                   input int ymin, input int maxit);
    longint cr, ci, zr, zi, nzr, nzi;
    int n;
    cr = longint'(xmin) + longint'(px) * 154;
    ci = longint'(ymin) + longint'(py) * 154;
    zr = 0; zi = 0; n = 0;
    while ((zr * zr + zi * zi) <= (longint'(4) << 26) && n != maxit) begin
      nzr = wrap18(((zr * zr - zi * zi) >>> 13) + cr);
      nzi = wrap18(((2 * zr * zi) >>> 13) + ci);
      zr = nzr; zi = nzi; n++;
    end
    return n;
  endfunction

  function automatic int ref_colour(input int n, input int maxit);
    if (n == maxit) return 0;
    if (n % 8 == 0) return 7;
    return n % 8;
  endfunction

  // ---------------- DUTs ----------------
  logic rst_a = 1'b1, start_a = 1'b0, done_a, plot_a;
  logic [7:0] x_a; logic [6:0] y_a; logic [2:0] col_a;
  logic rst_b = 1'b1, start_b = 1'b0, done_b, plot_b;
  logic [7:0] x_b; logic [6:0] y_b; logic [2:0] col_b;
  logic rst_c = 1'b1, start_c = 1'b0, done_c, plot_c;
  logic [7:0] x_c; logic [6:0] y_c; logic [2:0] col_c;

  mandelbrot_pixel_engine dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .done(done_a),
    .vga_x(x_a), .vga_y(y_a), .vga_colour(col_a), .vga_plot(plot_a));

  // pixel (0,0) here has the same c as pixel (106,60) of the default frame
  mandelbrot_pixel_engine #(.X_MIN(-60), .Y_MIN(24)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .done(done_b),
    .vga_x(x_b), .vga_y(y_b), .vga_colour(col_b), .vga_plot(plot_b));

  mandelbrot_pixel_engine #(.MAX_ITER(1)) dut_c (
    .clk(clk), .rst(rst_c), .start(start_c), .done(done_c),
    .vga_x(x_c), .vga_y(y_c), .vga_colour(col_c), .vga_plot(plot_c));

  typedef struct { int x; int y; int col; int t; int dn; } pulse_t;
  pulse_t qa[$], qb[$], qc[$];

  always @(negedge clk) begin
    if (plot_a === 1'b1) qa.push_back('{int'(x_a), int'(y_a), int'(col_a), pcyc, int'(done_a)});
    if (plot_b === 1'b1) qb.push_back('{int'(x_b), int'(y_b), int'(col_b), pcyc, int'(done_b)});
    if (plot_c === 1'b1) qc.push_back('{int'(x_c), int'(y_c), int'(col_c), pcyc, int'(done_c)});
  end

  function automatic int qsize(input int which);
    if (which == 0) return qa.size();
    if (which == 1) return qb.size();
    return qc.size();
  endfunction

  task automatic wait_pulses(input int which, input int n, input int budget, input string name);
    int k = 0;
    while (qsize(which) < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(qsize(which) >= n), 1);
  endtask

  typedef struct { int x; int y; int col; } vec_t;
  vec_t vecs[9];

  // ---------------- default instance ----------------
  task automatic run_a();
    int t0, limit, nplots, base, exp_n;
    vecs[0] = '{0, 0, 1};
    vecs[1] = '{5, 0, 1};
    vecs[2] = '{18, 0, 1};
    for (int i = 3; i < 9; i++) begin
      vecs[i].x   = int'($urandom_range(0, 159));
      vecs[i].y   = int'($urandom_range(0, 2));
      vecs[i].col = ref_colour(ref_count(vecs[i].x, vecs[i].y, -16384, -9216, 16), 16);
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("a_reset_done", done_a, 0);
    check("a_reset_plot", plot_a, 0);
    check("a_reset_x", x_a, 0);
    check("a_reset_y", y_a, 0);
    check("a_reset_colour", col_a, 0);
    rst_a = 1'b0;
    repeat (100) @(negedge clk);
    check("a_idle_no_plot", qa.size(), 0);
    check("a_idle_done", done_a, 0);

    t0 = pcyc;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_pulses(0, 1, 100, "a_first_pulse_timeout");
    if (qa.size() >= 1) begin
      check("a_first_time", qa[0].t, t0 + 4);
      check("a_first_x", qa[0].x, 0);
      check("a_first_y", qa[0].y, 0);
      check("a_first_colour", qa[0].col, 1);
    end

    wait_pulses(0, 200, 20000, "a_200_timeout");
    repeat ($urandom_range(0, 7)) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;

    limit = 500 + int'($urandom_range(0, 40));
    wait_pulses(0, limit, 40000, "a_limit_timeout");
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    check("a_midrst_plot", plot_a, 0);
    check("a_midrst_done", done_a, 0);
    nplots = qa.size();
    repeat (50) @(negedge clk);
    check("a_midrst_quiet", qa.size(), nplots);

    for (int i = 0; i < nplots; i++) begin
      exp_n = ref_count(i % 160, i / 160, -16384, -9216, 16);
      check($sformatf("a_px%0d_x", i), qa[i].x, i % 160);
      check($sformatf("a_px%0d_y", i), qa[i].y, i / 160);
      check($sformatf("a_px%0d_colour", i), qa[i].col, ref_colour(exp_n, 16));
      if (i > 0) check($sformatf("a_px%0d_span", i), qa[i].t - qa[i-1].t, exp_n + 3);
    end
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].y * 160 + vecs[i].x < nplots)
        check($sformatf("a_vec%0d_colour", i), qa[vecs[i].y * 160 + vecs[i].x].col, vecs[i].col);
    end

    base = qa.size();
    t0 = pcyc;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_pulses(0, base + 1, 100, "a_restart_timeout");
    if (qa.size() > base) begin
      check("a_restart_time", qa[base].t, t0 + 4);
      check("a_restart_x", qa[base].x, 0);
      check("a_restart_y", qa[base].y, 0);
    end

    wait_pulses(0, base + 20, 2000, "a_pre_rststart_timeout");
    rst_a = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    start_a = 1'b0;
    nplots = qa.size();
    repeat (40) @(negedge clk);
    check("a_rst_beats_start", qa.size(), nplots);
    check("a_rst_beats_start_done", done_a, 0);
  endtask

  // ---------------- in-set first pixel ----------------
  task automatic run_b();
    int t0, n1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    t0 = pcyc;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    wait_pulses(1, 2, 200, "b_pulses_timeout");
    if (qb.size() >= 2) begin
      check("b_inset_time", qb[0].t, t0 + 19);
      check("b_inset_colour", qb[0].col, 0);
      check("b_inset_x", qb[0].x, 0);
      check("b_inset_y", qb[0].y, 0);
      n1 = ref_count(1, 0, -60, 24, 16);
      check("b_second_span", qb[1].t - qb[0].t, n1 + 3);
      check("b_second_colour", qb[1].col, ref_colour(n1, 16));
    end
  endtask

  // ---------------- full frame (MAX_ITER=1) ----------------
  task automatic run_c();
    int t0, done_t, k, bad_pos, bad_col, bad_span, bad_done, nframe;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_c = 1'b0;
    check("c_reset_done", done_c, 0);
    @(negedge clk);
    t0 = pcyc;
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    k = 0;
    while (done_c !== 1'b1 && k < 80000) begin
      @(negedge clk);
      k++;
    end
    done_t = pcyc;
    check("c_done_rise", done_c, 1);
    nframe = qc.size();
    check("c_frame_pulses", nframe, 19200);
    if (nframe > 0) check("c_done_time", done_t, qc[nframe-1].t + 1);
    bad_pos = 0; bad_col = 0; bad_span = 0; bad_done = 0;
    for (int i = 0; i < nframe; i++) begin
      if (qc[i].x != i % 160 || qc[i].y != i / 160) bad_pos++;
      if (qc[i].col != 0) bad_col++;
      if (qc[i].t != t0 + 4 * (i + 1)) bad_span++;
      if (qc[i].dn != 0) bad_done++;
    end
    check("c_raster_bad", bad_pos, 0);
    check("c_colour_bad", bad_col, 0);
    check("c_timing_bad", bad_span, 0);
    check("c_done_early", bad_done, 0);
    repeat (20) @(negedge clk);
    check("c_done_hold", done_c, 1);
    check("c_no_extra_pulses", qc.size(), nframe);

    t0 = pcyc;
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    check("c_done_clear", done_c, 0);
    wait_pulses(2, nframe + 40, 400, "c_second_timeout");
    bad_pos = 0;
    for (int i = 0; i < 40 && nframe + i < qc.size(); i++) begin
      if (qc[nframe+i].x != i % 160 || qc[nframe+i].y != i / 160 ||
          qc[nframe+i].col != 0 || qc[nframe+i].t != t0 + 4 * (i + 1)) bad_pos++;
    end
    check("c_second_frame_bad", bad_pos, 0);
  endtask

  initial begin
    fork
      run_a();
      run_b();
      run_c();
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", checks);
    $fatal(1);
  end

endmodule
